// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: decodes the IR opcode against a one-hot
// step state (T0..T7) and drives every datapath strobe for fetch, decode and execute.
module control_sequencer #(
  parameter int unsigned     OPW     = 5,
  parameter logic [OPW-1:0]  ALU_ADD = 5'b00011
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    ir,
  input  logic           con_ff,
  output logic           pci,
  output logic           pco,
  output logic           iri,
  output logic           mari,
  output logic           mdri,
  output logic           mdro,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ryi,
  output logic           rzli,
  output logic           rzhi,
  output logic           rzlo,
  output logic           rzho,
  output logic           hii,
  output logic           hio,
  output logic           loi,
  output logic           loo,
  output logic           gra,
  output logic           grb,
  output logic           grc,
  output logic           rin,
  output logic           rout,
  output logic           baout,
  output logic           csigno,
  output logic           opi,
  output logic           ipo,
  output logic           incpc,
  output logic           conin,
  output logic [OPW-1:0] alu_op,
  output logic           run
);

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(10);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(11);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(13);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(14);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(15);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(16);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(17);
  localparam logic [OPW-1:0] OP_BR   = OPW'(18);
  localparam logic [OPW-1:0] OP_JR   = OPW'(19);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(20);
  localparam logic [OPW-1:0] OP_IN   = OPW'(21);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(22);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(23);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(24);
  localparam logic [OPW-1:0] OP_HALT = OPW'(26);

  typedef enum logic [9:0] {
    S_RST  = 10'b00_0000_0001,
    S_T0   = 10'b00_0000_0010,
    S_T1   = 10'b00_0000_0100,
    S_T2   = 10'b00_0000_1000,
    S_T3   = 10'b00_0001_0000,
    S_T4   = 10'b00_0010_0000,
    S_T5   = 10'b00_0100_0000,
    S_T6   = 10'b00_1000_0000,
    S_T7   = 10'b01_0000_0000,
    S_HALT = 10'b10_0000_0000
  } state_e;

  state_e state_q, state_d, last_step;

  logic [OPW-1:0] op;
  logic           is_mem, is_alu, is_imm, is_muldiv, is_unary, has_exec;
  logic           unused_ir;

  assign op        = ir[31:32-OPW];
  assign unused_ir = ^ir[31-OPW:0];

  // Opcode classes sharing a step pattern
  assign is_mem    = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  assign is_alu    = (op >= OP_ADD) && (op <= OP_ORI);
  assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_unary  = (op == OP_NEG) || (op == OP_NOT);
  assign has_exec  = (op <= OP_MFLO);

  // Final execute step of the current opcode
  always_comb begin
    last_step = S_T3;
    if ((op == OP_LD) || (op == OP_ST))           last_step = S_T7;
    else if ((op == OP_LDI) || is_alu)            last_step = S_T5;
    else if (is_muldiv || (op == OP_BR))          last_step = S_T6;
    else if (is_unary || (op == OP_JAL))          last_step = S_T4;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (op == OP_HALT)  state_d = S_HALT;
        else if (!has_exec) state_d = S_T0;
        else                state_d = S_T3;
      end
      S_T3:   state_d = (last_step == S_T3) ? S_T0 : S_T4;
      S_T4:   state_d = (last_step == S_T4) ? S_T0 : S_T5;
      S_T5:   state_d = (last_step == S_T5) ? S_T0 : S_T6;
      S_T6:   state_d = (last_step == S_T6) ? S_T0 : S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Strobe decode: pure function of step and opcode (con_ff gates branch T6)
  always_comb begin
    pci = 1'b0; pco = 1'b0; iri = 1'b0; mari = 1'b0; mdri = 1'b0; mdro = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    ryi = 1'b0; rzli = 1'b0; rzhi = 1'b0; rzlo = 1'b0; rzho = 1'b0;
    hii = 1'b0; hio = 1'b0; loi = 1'b0; loo = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
    baout = 1'b0; csigno = 1'b0;
    opi = 1'b0; ipo = 1'b0; incpc = 1'b0; conin = 1'b0;
    alu_op = '0;
    run = (state_q != S_RST) && (state_q != S_HALT);

    case (state_q)
      S_T0: begin
        pco = 1'b1; mari = 1'b1; incpc = 1'b1; rzli = 1'b1;
      end
      S_T1: begin
        rzlo = 1'b1; pci = 1'b1; mem_read = 1'b1; mdri = 1'b1;
      end
      S_T2: begin
        mdro = 1'b1; iri = 1'b1;
      end
      S_T3: begin
        if (is_mem) begin
          grb = 1'b1; baout = 1'b1; ryi = 1'b1;
        end else if (is_alu) begin
          grb = 1'b1; rout = 1'b1; ryi = 1'b1;
        end else if (is_muldiv) begin
          gra = 1'b1; rout = 1'b1; ryi = 1'b1;
        end else if (is_unary) begin
          grb = 1'b1; rout = 1'b1; alu_op = op; rzli = 1'b1;
        end else if (op == OP_BR) begin
          gra = 1'b1; rout = 1'b1; conin = 1'b1;
        end else if (op == OP_JR) begin
          gra = 1'b1; rout = 1'b1; pci = 1'b1;
        end else if (op == OP_JAL) begin
          pco = 1'b1; grb = 1'b1; rin = 1'b1;
        end else if (op == OP_IN) begin
          ipo = 1'b1; gra = 1'b1; rin = 1'b1;
        end else if (op == OP_OUT) begin
          gra = 1'b1; rout = 1'b1; opi = 1'b1;
        end else if (op == OP_MFHI) begin
          hio = 1'b1; gra = 1'b1; rin = 1'b1;
        end else if (op == OP_MFLO) begin
          loo = 1'b1; gra = 1'b1; rin = 1'b1;
        end
      end
      S_T4: begin
        if (is_mem) begin
          csigno = 1'b1; alu_op = ALU_ADD; rzli = 1'b1;
        end else if (is_alu) begin
          alu_op = op; rzli = 1'b1;
          if (is_imm) csigno = 1'b1;
          else begin
            grc = 1'b1; rout = 1'b1;
          end
        end else if (is_muldiv) begin
          grb = 1'b1; rout = 1'b1; alu_op = op; rzli = 1'b1; rzhi = 1'b1;
        end else if (is_unary) begin
          rzlo = 1'b1; gra = 1'b1; rin = 1'b1;
        end else if (op == OP_BR) begin
          pco = 1'b1; ryi = 1'b1;
        end else if (op == OP_JAL) begin
          gra = 1'b1; rout = 1'b1; pci = 1'b1;
        end
      end
      S_T5: begin
        if ((op == OP_LD) || (op == OP_ST)) begin
          rzlo = 1'b1; mari = 1'b1;
        end else if ((op == OP_LDI) || is_alu) begin
          rzlo = 1'b1; gra = 1'b1; rin = 1'b1;
        end else if (is_muldiv) begin
          rzlo = 1'b1; loi = 1'b1;
        end else if (op == OP_BR) begin
          csigno = 1'b1; alu_op = ALU_ADD; rzli = 1'b1;
        end
      end
      S_T6: begin
        if (op == OP_LD) begin
          mem_read = 1'b1; mdri = 1'b1;
        end else if (op == OP_ST) begin
          gra = 1'b1; rout = 1'b1; mdri = 1'b1;
        end else if (is_muldiv) begin
          rzho = 1'b1; hii = 1'b1;
        end else if ((op == OP_BR) && con_ff) begin
          rzlo = 1'b1; pci = 1'b1;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          mdro = 1'b1; gra = 1'b1; rin = 1'b1;
        end else if (op == OP_ST) begin
          mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
